led_refresh_ctrl: RTL and testbench
===================================

Name: led_refresh_ctrl

Overview:
- Frame scheduler that sits upstream of the LED serial sender and its 24-bit RGB FIFO.
- On each refresh tick, or on a manual trigger, it reads LED_NUM pixels from a pixel source (1-cycle-latency read port) and writes them into the FIFO.
- It then pulses the sender's enable and tracks the sender's FIFO read strobes to detect end of transmission.
- Provides frame pacing, frame-overrun detection and a transmission timeout.

Parameters:
- LED_NUM, 4, LEDs per frame; pixel addresses 0..LED_NUM-1.
- ADDR_W, 8, pixel address width; LED_NUM <= 2**ADDR_W is required.
- PERIOD_W, 24, width of the refresh period register and timer.
- TIMEOUT_CYC, 4096, maximum clk cycles allowed in WAIT_TX.

Ports:
- clk  in  1  system clock (150 MHz domain)
- rst  in  1  asynchronous, active-high reset
- refresh_en  in  1  enables the periodic refresh timer
- period  in  PERIOD_W  refresh period in clk cycles; 0 is treated as disabled
- trig  in  1  one-cycle manual frame request
- pix_rd  out  1  pixel read strobe
- pix_addr  out  ADDR_W  pixel address, valid with pix_rd
- pix_data  in  24  RGB data, valid the cycle after pix_rd
- fifo_wr  out  1  FIFO write strobe
- fifo_wdata  out  24  FIFO write data
- fifo_full  in  1  FIFO full
- snd_enable  out  1  one-cycle start pulse to the sender
- snd_rd  in  1  snooped sender FIFO read strobe (one pulse per 32-bit word shifted)
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse at end of a successful frame
- overrun  out  1  sticky; set when a request arrives while one is already pending
- tx_timeout  out  1  sticky; set on WAIT_TX timeout
- clr_err  in  1  clears overrun and tx_timeout
- frame_cnt  out  16  count of completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, pending flag 0.

Refresh timer:
- Free-runs while refresh_en=1 and period!=0.
- Counts 0..period-1; tick is one cycle at count==period-1, then the count wraps to 0.
- refresh_en=0 or period=0 holds the timer at 0.
- A change of period takes effect at the next wrap.

Request handling:
- request = tick | trig; simultaneous tick and trig count as one request.
- In IDLE, a request starts a frame next cycle.
- Otherwise the request sets pending.
- If pending is already 1, overrun is set; at most one request is queued.

State machine IDLE -> FILL -> KICK -> WAIT_TX -> IDLE.
- IDLE: on request or pending, go to FILL, clear pending, reset the pixel index to 0.
- FILL:
  - Issues pix_rd with pix_addr=index only when fifo_full=0 and no read is outstanding; at most one pixel is in flight.
  - In the following cycle, fifo_wr=1 and fifo_wdata=pix_data, and index increments.
  - A fill therefore takes at least 2*LED_NUM cycles.
  - If fifo_full rises, no new pix_rd is issued. The in-flight write still occurs; the FIFO must have at least 1 entry of slack after full.
  - After the LED_NUM-th write, go to KICK.
- KICK: snd_enable=1 for exactly one cycle, then go to WAIT_TX.
- WAIT_TX:
  - Counts snd_rd pulses. The sender produces LED_NUM+3 pulses per frame (start word, LED words, end word, final).
  - On the pulse that brings the count to LED_NUM+3: frame_done=1 for one cycle, frame_cnt+1, go to IDLE.
  - A cycle counter starts at 0 on entry. When it reaches TIMEOUT_CYC-1: tx_timeout=1, go to IDLE, no frame_done, frame_cnt unchanged.
- snd_rd outside WAIT_TX is ignored.
- A pending request is serviced on the cycle after return to IDLE, so back-to-back frames are separated by 1 IDLE cycle.
- clr_err has priority over a set in the same cycle (clear wins).
- trig while busy behaves like a tick while busy.
- Asynchronous reset mid-frame aborts immediately and returns all outputs to their reset values. The FIFO is not flushed by this block.

Test Plan:
- LED_NUM=4, period=0, trig pulse, pix_data=addr*0x010101 -> pix_addr 0,1,2,3; fifo_wdata 0x000000, 0x010101, 0x020202, 0x030303; then one snd_enable; 7 snd_rd pulses -> one frame_done, frame_cnt=1, busy low next cycle.
- refresh_en=1, period=100, sender model responding within 60 cycles -> snd_enable every 100 cycles; overrun stays 0 over 5 frames; frame_cnt=5.
- period=20 with a sender taking 60 cycles -> overrun=1 after the second queued tick; exactly one pending frame starts 1 cycle after each frame_done; clr_err -> overrun=0.
- fifo_full held high for 10 cycles after the 2nd write -> no pix_rd while full; fill completes with 4 writes in order and no data lost.
- Sender never returns snd_rd -> tx_timeout=1 exactly TIMEOUT_CYC cycles after WAIT_TX entry; frame_done never pulses; state IDLE; next trig starts a normal frame.
- rst asserted during FILL at index 2 -> outputs 0 asynchronously; after release, trig restarts from pix_addr 0; frame_cnt=0.

Source files
------------

// File: rtl/led_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// led_refresh_ctrl
//
// Frame scheduler in front of the LED serial sender and its 24-bit RGB FIFO.
// A periodic refresh tick or a manual trigger requests a frame. The block then
// copies LED_NUM pixels from a 1-cycle-latency pixel source into the FIFO,
// pulses the sender enable, and counts the sender's FIFO read strobes to detect
// the end of transmission. A timeout guards against a sender that never
// finishes.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   refresh_en  enables the periodic refresh timer
//   period      refresh period in clk cycles (0 = timer disabled)
//   trig        one-cycle manual frame request
//   pix_rd      pixel read strobe
//   pix_addr    pixel address, valid with pix_rd
//   pix_data    RGB pixel data, valid the cycle after pix_rd
//   fifo_wr     FIFO write strobe
//   fifo_wdata  FIFO write data
//   fifo_full   FIFO full flag
//   snd_enable  one-cycle start pulse to the sender
//   snd_rd      snooped sender FIFO read strobe
//   busy        high whenever the scheduler is not idle
//   frame_done  one-cycle pulse after a successful frame
//   overrun     sticky: request arrived while another was already queued
//   tx_timeout  sticky: sender did not finish within TIMEOUT_CYC cycles
//   clr_err     clears overrun and tx_timeout (clear beats a same-cycle set)
//   frame_cnt   completed frame counter, wraps
// ----------------------------------------------------------------------------
module led_refresh_ctrl #(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refresh_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                trig,
    output logic                pix_rd,
    output logic [ADDR_W-1:0]   pix_addr,
    input  logic [23:0]         pix_data,
    output logic                fifo_wr,
    output logic [23:0]         fifo_wdata,
    input  logic                fifo_full,
    output logic                snd_enable,
    input  logic                snd_rd,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic                tx_timeout,
    input  logic                clr_err,
    output logic [15:0]         frame_cnt
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_KICK = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    // Pixel index needs one extra bit so LED_NUM == 2**ADDR_W still fits.
    localparam int unsigned IDX_W = ADDR_W + 1;
    // Sender emits start word + LED words + end word + final strobe.
    localparam int unsigned SND_PULSES = LED_NUM + 3;
    localparam int unsigned SND_W = $clog2(SND_PULSES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(LED_NUM - 1);
    localparam logic [SND_W-1:0]    LAST_SND  = SND_W'(SND_PULSES - 1);
    localparam logic [TO_W-1:0]     LAST_WAIT = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_inflight;
    logic [SND_W-1:0]    r_snd_cnt;
    logic [TO_W-1:0]     r_wait_cnt;
    logic                r_pending;
    logic                r_overrun;
    logic                r_tx_timeout;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;
    logic [PERIOD_W-1:0] r_timer;
    logic [PERIOD_W-1:0] r_per_act;

    logic                w_tmr_en;
    logic [PERIOD_W-1:0] w_cur_per;
    logic                w_tick;
    logic                w_req;
    logic                w_idle;
    logic                w_start;
    logic                w_pix_rd;
    logic                w_done_fire;
    logic                w_tmo_fire;

    // ------------------------------------------------------------------------
    // Refresh timer
    // ------------------------------------------------------------------------
    // The active period is captured whenever the timer is held or wraps, so a
    // new period value only takes effect at the next wrap. If the captured
    // value is still 0 (timer was just enabled this cycle), fall back to the
    // live input.
    assign w_tmr_en  = refresh_en && (period != '0);
    assign w_cur_per = (r_per_act == '0) ? period : r_per_act;
    assign w_tick    = w_tmr_en && (r_timer >= (w_cur_per - PER_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_per_act <= '0;
        end else if (!w_tmr_en) begin
            r_timer   <= '0;
            r_per_act <= period;
        end else if (w_tick) begin
            r_timer   <= '0;
            r_per_act <= period;
        end else begin
            r_timer   <= r_timer + PER_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Request queueing
    // ------------------------------------------------------------------------
    assign w_req   = w_tick | trig;
    assign w_idle  = (r_state == S_IDLE);
    assign w_start = w_idle && (w_req || r_pending);

    // In IDLE a start consumes the pending slot; a request arriving in that
    // same cycle is queued behind it rather than dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_idle) begin
            r_pending <= r_pending & w_req;
        end else if (w_req) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
        end else if (!w_idle && w_req && r_pending) begin
            r_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------------
    // One pixel in flight at most: a read is only issued when the previous
    // read's write has been performed.
    assign w_pix_rd = (r_state == S_FILL) && !r_inflight && !fifo_full;

    // Completion wins over a timeout landing in the same cycle.
    assign w_done_fire = (r_state == S_WAIT) && snd_rd && (r_snd_cnt == LAST_SND);
    assign w_tmo_fire  = (r_state == S_WAIT) && !w_done_fire && (r_wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_inflight <= 1'b0;
            r_snd_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_FILL;
                        r_idx      <= '0;
                        r_inflight <= 1'b0;
                    end
                end
                S_FILL: begin
                    r_inflight <= w_pix_rd;
                    if (r_inflight) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_KICK;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_KICK: begin
                    r_state    <= S_WAIT;
                    r_snd_cnt  <= '0;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_done_fire || w_tmo_fire) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                        if (snd_rd) begin
                            r_snd_cnt <= r_snd_cnt + SND_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_done_fire;
            if (w_done_fire) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_timeout <= 1'b0;
        end else if (clr_err) begin
            r_tx_timeout <= 1'b0;
        end else if (w_tmo_fire) begin
            r_tx_timeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // fifo_wdata is a pass-through of the pixel source during the write cycle,
    // which is exactly the cycle after the corresponding pix_rd.
    assign pix_rd     = w_pix_rd;
    assign pix_addr   = r_idx[ADDR_W-1:0];
    assign fifo_wr    = r_inflight;
    assign fifo_wdata = r_inflight ? pix_data : '0;
    assign snd_enable = (r_state == S_KICK);
    assign busy       = !w_idle;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign tx_timeout = r_tx_timeout;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_led_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_refresh_ctrl
//
// Directed bench for led_refresh_ctrl with default parameters (LED_NUM=4,
// TIMEOUT_CYC=4096). A pixel source returns addr*0x010101 one cycle after
// pix_rd; a sender model answers snd_enable with 7 snd_rd pulses after a
// programmable latency (0 = silent).
// ----------------------------------------------------------------------------
module tb_led_refresh_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        refresh_en;
    logic [23:0] period;
    logic        trig;
    logic        pix_rd;
    logic [7:0]  pix_addr;
    logic [23:0] pix_data;
    logic        fifo_wr;
    logic [23:0] fifo_wdata;
    logic        fifo_full;
    logic        snd_enable;
    logic        snd_rd;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        tx_timeout;
    logic        clr_err;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int snd_lat = 5;

    int addr_q[$];
    int data_q[$];
    int en_q[$];
    int done_q[$];
    int start_q[$];
    int tmo_cyc = -1;
    int rd_while_full = 0;
    logic prev_busy = 1'b0;
    logic prev_tmo  = 1'b0;

    led_refresh_ctrl #(
        .LED_NUM    (4),
        .ADDR_W     (8),
        .PERIOD_W   (24),
        .TIMEOUT_CYC(4096)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .refresh_en(refresh_en),
        .period    (period),
        .trig      (trig),
        .pix_rd    (pix_rd),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .fifo_wr   (fifo_wr),
        .fifo_wdata(fifo_wdata),
        .fifo_full (fifo_full),
        .snd_enable(snd_enable),
        .snd_rd    (snd_rd),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun),
        .tx_timeout(tx_timeout),
        .clr_err   (clr_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source: fixed 1-cycle read latency
    always @(posedge clk) begin
        if (pix_rd) pix_data <= 24'(pix_addr) * 24'h010101;
    end

    // Observation, away from the active edge
    always @(negedge clk) begin
        if (pix_rd) begin
            addr_q.push_back(int'(pix_addr));
            if (fifo_full) rd_while_full++;
        end
        if (fifo_wr)    data_q.push_back(int'(fifo_wdata));
        if (snd_enable) en_q.push_back(cyc);
        if (frame_done) done_q.push_back(cyc);
        if (busy && !prev_busy) start_q.push_back(cyc);
        if (tx_timeout && !prev_tmo) tmo_cyc = cyc;
        prev_busy = busy;
        prev_tmo  = tx_timeout;
    end

    // Sender model
    initial begin
        snd_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (snd_enable && snd_lat > 0) begin
                repeat (snd_lat) @(posedge clk);
                for (int p = 0; p < 7; p++) begin
                    #1 snd_rd = 1'b1;
                    @(posedge clk);
                    #1 snd_rd = 1'b0;
                    @(posedge clk);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        addr_q.delete();
        data_q.delete();
        en_q.delete();
        done_q.delete();
        start_q.delete();
        tmo_cyc = -1;
        rd_while_full = 0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        refresh_en = 1'b0;
        period     = '0;
        trig       = 1'b0;
        fifo_full  = 1'b0;
        clr_err    = 1'b0;
        snd_lat    = 5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic pulse_trig(output int t);
        @(posedge clk);
        #1 trig = 1'b1;
        t = cyc;
        @(posedge clk);
        #1 trig = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        int quiet = 0;
        while (quiet < 3 && k < budget) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            k++;
        end
        check(tag, 32'(quiet), 32'd3);
    endtask

    initial begin
        int t;
        int k;

        rst = 1'b1;
        pix_data = '0;
        // --- reset state -----------------------------------------------------
        do_reset();
        @(negedge clk);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_pix_rd",     32'(pix_rd),     32'd0);
        check("rst_fifo_wr",    32'(fifo_wr),    32'd0);
        check("rst_snd_enable", 32'(snd_enable), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'd0);

        // --- single manual frame ---------------------------------------------
        pulse_trig(t);
        wait_dones("t1_done_seen", 1, 100);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 32'(qget(addr_q, i)), 32'(i));
            check($sformatf("t1_data%0d", i), 32'(qget(data_q, i)), 32'(i * 32'h010101));
        end
        check("t1_wr_count",  32'(data_q.size()), 32'd4);
        check("t1_en_count",  32'(en_q.size()), 32'd1);
        check("t1_en_latency", 32'(qget(en_q, 0) - t), 32'd9);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_done_1cyc", 32'(frame_done), 32'd0);
        check("t1_done_count", 32'(done_q.size()), 32'd1);

        // --- periodic refresh, period 100 ------------------------------------
        do_reset();
        snd_lat = 20;
        @(posedge clk);
        #1 period = 24'd100;
        refresh_en = 1'b1;
        k = 0;
        while (frame_cnt != 16'd5 && k < 700) begin
            @(negedge clk);
            k++;
        end
        refresh_en = 1'b0;
        check("t2_frame_cnt", 32'(frame_cnt), 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_interval%0d", i), 32'(qget(en_q, i + 1) - qget(en_q, i)), 32'd100);
        check("t2_overrun", 32'(overrun), 32'd0);
        wait_idle("t2_idle", 200);

        // --- overrun with period 20 and a slow sender ------------------------
        do_reset();
        snd_lat = 46;
        @(posedge clk);
        #1 period = 24'd20;
        refresh_en = 1'b1;
        wait_dones("t3_first_done", 1, 200);
        check("t3_overrun_set", 32'(overrun), 32'd1);
        wait_dones("t3_third_done", 3, 300);
        check("t3_pend_start1", 32'(qget(start_q, 1) - qget(done_q, 0)), 32'd1);
        check("t3_pend_start2", 32'(qget(start_q, 2) - qget(done_q, 1)), 32'd1);
        refresh_en = 1'b0;
        wait_idle("t3_drain", 400);
        check("t3_start_eq_done", 32'(start_q.size()), 32'(done_q.size()));
        check("t3_frame_cnt", 32'(frame_cnt), 32'(done_q.size()));
        pulse_clr();
        @(negedge clk);
        check("t3_overrun_clr", 32'(overrun), 32'd0);

        // --- FIFO full back-pressure -----------------------------------------
        do_reset();
        pulse_trig(t);
        k = 0;
        while (data_q.size() < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        fifo_full = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_wr_frozen", 32'(data_q.size()), 32'd2);
        check("t4_rd_frozen", 32'(addr_q.size()), 32'd2);
        fifo_full = 1'b0;
        wait_dones("t4_done", 1, 100);
        check("t4_rd_while_full", 32'(rd_while_full), 32'd0);
        check("t4_wr_count", 32'(data_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_data%0d", i), 32'(qget(data_q, i)), 32'(i * 32'h010101));

        // --- transmission timeout --------------------------------------------
        do_reset();
        snd_lat = 0;
        pulse_trig(t);
        k = 0;
        while (tmo_cyc < 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("t5_tmo_set", 32'(tx_timeout), 32'd1);
        check("t5_tmo_time", 32'(tmo_cyc - qget(en_q, 0)), 32'd4097);
        check("t5_no_done", 32'(done_q.size()), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        snd_lat = 5;
        clear_logs();
        pulse_trig(t);
        wait_dones("t5_next_done", 1, 100);
        check("t5_next_cnt", 32'(frame_cnt), 32'd1);
        check("t5_tmo_sticky", 32'(tx_timeout), 32'd1);
        pulse_clr();
        @(negedge clk);
        check("t5_tmo_clr", 32'(tx_timeout), 32'd0);

        // --- asynchronous reset during FILL ----------------------------------
        do_reset();
        pulse_trig(t);
        k = 0;
        while (!(pix_rd && pix_addr == 8'd2) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_reached_idx2", 32'(pix_addr), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t6_async_busy",   32'(busy),    32'd0);
        check("t6_async_pix_rd", 32'(pix_rd),  32'd0);
        check("t6_async_addr",   32'(pix_addr), 32'd0);
        check("t6_async_wr",     32'(fifo_wr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        check("t6_cnt_after_rst", 32'(frame_cnt), 32'd0);
        pulse_trig(t);
        wait_dones("t6_done", 1, 100);
        check("t6_first_addr", 32'(qget(addr_q, 0)), 32'd0);
        check("t6_addr_count", 32'(addr_q.size()), 32'd4);
        check("t6_frame_cnt",  32'(frame_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
